// File: rtl/enc_mac_accum_if.sv
// Handshake/bus bundle for enc_mac_accum: address beats, BRAM read data,
// result stream and status. The block uses the slave modport; its driver uses master.
interface enc_mac_accum_if #(
    parameter int Q_BITS = 16
);
    logic              addr_valid_in;
    logic [12:0]       b_addr_in;
    logic              e_zero_in;
    logic              done_in;
    logic [Q_BITS-1:0] A_data_in;
    logic [Q_BITS-1:0] s_data_in;
    logic [Q_BITS-1:0] e_data_in;
    logic [Q_BITS-1:0] b_data_out;
    logic [6:0]        b_idx_out;
    logic              b_valid_out;
    logic              b_ready_in;
    logic              busy_out;
    logic              out_done_out;
    logic              err_out;
    logic [31:0]       mac_count_out;

    modport slave (
        input  addr_valid_in, b_addr_in, e_zero_in, done_in,
        input  A_data_in, s_data_in, e_data_in, b_ready_in,
        output b_data_out, b_idx_out, b_valid_out,
        output busy_out, out_done_out, err_out, mac_count_out
    );

    modport master (
        output addr_valid_in, b_addr_in, e_zero_in, done_in,
        output A_data_in, s_data_in, e_data_in, b_ready_in,
        input  b_data_out, b_idx_out, b_valid_out,
        input  busy_out, out_done_out, err_out, mac_count_out
    );
endinterface

// File: rtl/enc_mac_accum.sv
// Modular multiply-accumulate into HALF_DEPTH accumulators, then streamed out in index order.
// Optional feature: define ENC_MAC_ACCUM_PERF_EN to enable the mac_count_out beat counter.
module enc_mac_accum #(
    parameter int HALF_DEPTH = 50,
    parameter int Q_BITS     = 16,
    parameter int READ_LAT   = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    enc_mac_accum_if.slave  bus
);
    localparam int AW = (HALF_DEPTH > 1) ? $clog2(HALF_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    state_t            state_q, state_d;
    logic              done_prev_q, done_prev_d;
    logic              pv_q [READ_LAT];
    logic              pv_d [READ_LAT];
    logic [12:0]       pa_q [READ_LAT];
    logic [12:0]       pa_d [READ_LAT];
    logic              pe_q [READ_LAT];
    logic              pe_d [READ_LAT];
    logic              m_valid_q, m_valid_d;
    logic [12:0]       m_addr_q, m_addr_d;
    logic [Q_BITS-1:0] term_q, term_d;
    logic [Q_BITS-1:0] acc_q [HALF_DEPTH];
    logic [Q_BITS-1:0] acc_d [HALF_DEPTH];
    logic              err_q, err_d;
    logic              b_valid_q, b_valid_d;
    logic [6:0]        b_idx_q, b_idx_d;
    logic [Q_BITS-1:0] b_data_q, b_data_d;
    logic              out_done_q, out_done_d;
    logic              busy_q, busy_d;
    logic [7:0]        drain_cnt_q, drain_cnt_d;
    logic [Q_BITS-1:0] prod_lo;
    logic              start;
    logic              accept;
    logic              w_in_range;

    always_comb begin
        state_d     = state_q;
        done_prev_d = bus.done_in;
        acc_d       = acc_q;
        err_d       = err_q;
        b_valid_d   = b_valid_q;
        b_idx_d     = b_idx_q;
        b_data_d    = b_data_q;
        out_done_d  = 1'b0;
        drain_cnt_d = drain_cnt_q;

        // A run may only start while done_in is seen low, so a level-held done is ignored.
        start  = (state_q == IDLE) && bus.addr_valid_in && !bus.done_in;
        accept = start || ((state_q == ACCUM) && bus.addr_valid_in);

        pv_d[0] = accept;
        pa_d[0] = bus.b_addr_in;
        pe_d[0] = bus.e_zero_in;
        for (int unsigned i = 1; i < READ_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pa_d[i] = pa_q[i-1];
            pe_d[i] = pe_q[i-1];
        end

        prod_lo   = bus.A_data_in * bus.s_data_in;
        term_d    = prod_lo + (pe_q[READ_LAT-1] ? '0 : bus.e_data_in);
        m_valid_d = pv_q[READ_LAT-1];
        m_addr_d  = pa_q[READ_LAT-1];

        // Read-modify-write in one cycle keeps back-to-back beats to one index exact.
        w_in_range = m_addr_q < 13'(HALF_DEPTH);
        if (m_valid_q) begin
            if (w_in_range) begin
                acc_d[AW'(m_addr_q)] = acc_q[AW'(m_addr_q)] + term_q;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '{default: '0};
                end
            end
            ACCUM: begin
                if (bus.done_in && !done_prev_q) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == 8'(READ_LAT + 1)) begin
                    state_d   = OUT;
                    b_valid_d = 1'b1;
                    b_idx_d   = '0;
                    b_data_d  = acc_q[0];
                end else begin
                    drain_cnt_d = drain_cnt_q + 8'd1;
                end
            end
            OUT: begin
                if (b_valid_q && bus.b_ready_in) begin
                    if (b_idx_q == 7'(HALF_DEPTH - 1)) begin
                        b_valid_d  = 1'b0;
                        out_done_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        b_idx_d  = b_idx_q + 7'd1;
                        b_data_d = acc_q[AW'(b_idx_q + 7'd1)];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            done_prev_q <= 1'b0;
            pv_q        <= '{default: '0};
            pa_q        <= '{default: '0};
            pe_q        <= '{default: '0};
            m_valid_q   <= 1'b0;
            m_addr_q    <= '0;
            term_q      <= '0;
            acc_q       <= '{default: '0};
            err_q       <= 1'b0;
            b_valid_q   <= 1'b0;
            b_idx_q     <= '0;
            b_data_q    <= '0;
            out_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            done_prev_q <= done_prev_d;
            pv_q        <= pv_d;
            pa_q        <= pa_d;
            pe_q        <= pe_d;
            m_valid_q   <= m_valid_d;
            m_addr_q    <= m_addr_d;
            term_q      <= term_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            b_valid_q   <= b_valid_d;
            b_idx_q     <= b_idx_d;
            b_data_q    <= b_data_d;
            out_done_q  <= out_done_d;
            busy_q      <= busy_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

`ifdef ENC_MAC_ACCUM_PERF_EN
    logic [31:0] mac_cnt_q, mac_cnt_d;

    always_comb begin
        mac_cnt_d = mac_cnt_q;
        if (m_valid_q && w_in_range) begin
            mac_cnt_d = mac_cnt_q + 32'd1;
        end
        if (start) begin
            mac_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mac_cnt_q <= '0;
        end else begin
            mac_cnt_q <= mac_cnt_d;
        end
    end

    assign bus.mac_count_out = mac_cnt_q;
`else
    assign bus.mac_count_out = '0;
`endif

    assign bus.b_data_out   = b_data_q;
    assign bus.b_idx_out    = b_idx_q;
    assign bus.b_valid_out  = b_valid_q;
    assign bus.busy_out     = busy_q;
    assign bus.out_done_out = out_done_q;
    assign bus.err_out      = err_q;
endmodule

// File: tb/tb_enc_mac_accum.sv
// Directed bench for enc_mac_accum: BRAM data delay model, accumulator reference model
// and an output scoreboard queue checked on every handshake.
module tb_enc_mac_accum;
    localparam int HD = 50;
    localparam int QB = 16;
    localparam int RL = 2;
`ifdef ENC_MAC_ACCUM_PERF_EN
    localparam int unsigned PERF = 1;
`else
    localparam int unsigned PERF = 0;
`endif

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    enc_mac_accum_if #(.Q_BITS(QB)) bus ();

    enc_mac_accum #(
        .HALF_DEPTH (HD),
        .Q_BITS     (QB),
        .READ_LAT   (RL)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] s;
        logic [15:0] e;
    } rd_t;

    typedef struct {
        logic [6:0]  idx;
        logic [15:0] data;
    } sb_t;

    rd_t         cur;
    rd_t         dl [RL];
    logic [15:0] exp_acc [HD];
    sb_t         sbq [$];
    int          total = 0;
    int          bad   = 0;

    // BRAM model: data for a beat appears RL cycles after the beat.
    always @(posedge clk_in) begin
        dl[0] <= cur;
        for (int i = 1; i < RL; i++) dl[i] <= dl[i-1];
    end
    assign bus.A_data_in = dl[RL-1].a;
    assign bus.s_data_in = dl[RL-1].s;
    assign bus.e_data_in = dl[RL-1].e;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        foreach (exp_acc[i]) exp_acc[i] = '0;
    endtask

    task automatic beat(int addr, logic [15:0] a, logic [15:0] s, logic [15:0] e,
                        logic ez, logic dn);
        logic [15:0] t;
        @(negedge clk_in);
        bus.addr_valid_in = 1'b1;
        bus.b_addr_in     = 13'(addr);
        bus.e_zero_in     = ez;
        bus.done_in       = dn;
        cur               = {a, s, e};
        if (addr < HD) begin
            t = a * s;
            if (!ez) t = t + e;
            exp_acc[addr] = exp_acc[addr] + t;
        end
    endtask

    task automatic quiet();
        @(negedge clk_in);
        bus.addr_valid_in = 1'b0;
    endtask

    task automatic zero_checks(string tag);
        check({tag, "_valid"}, 32'(bus.b_valid_out), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy_out), 32'd0);
        check({tag, "_err"}, 32'(bus.err_out), 32'd0);
        check({tag, "_odone"}, 32'(bus.out_done_out), 32'd0);
        check({tag, "_data"}, 32'(bus.b_data_out), 32'd0);
        check({tag, "_idx"}, 32'(bus.b_idx_out), 32'd0);
        check({tag, "_mac"}, bus.mac_count_out, 32'd0);
    endtask

    task automatic finish_accum(bit chk);
        @(negedge clk_in);
        bus.addr_valid_in = 1'b0;
        bus.done_in       = 1'b1;
        if (chk) begin
            repeat (RL + 2) @(negedge clk_in);
            check("drain_valid_low", 32'(bus.b_valid_out), 32'd0);
            check("drain_busy", 32'(bus.busy_out), 32'd1);
            @(negedge clk_in);
            check("out_first_valid", 32'(bus.b_valid_out), 32'd1);
            check("out_first_idx", 32'(bus.b_idx_out), 32'd0);
        end
    endtask

    task automatic out_phase(int stall_idx);
        sb_t sb;
        int  stall = 0;
        bit  fin   = 1'b0;
        for (int i = 0; i < HD; i++) sbq.push_back('{7'(i), exp_acc[i]});
        for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
            @(negedge clk_in);
            if (bus.b_valid_out) begin
                if (int'(bus.b_idx_out) == stall_idx && stall < 5) begin
                    bus.b_ready_in = 1'b0;
                    check("stall_idx", 32'(bus.b_idx_out), 32'(sbq[0].idx));
                    check("stall_data", 32'(bus.b_data_out), 32'(sbq[0].data));
                    stall++;
                end else begin
                    bus.b_ready_in = 1'b1;
                    sb = sbq.pop_front();
                    check("out_idx", 32'(bus.b_idx_out), 32'(sb.idx));
                    check("out_data", 32'(bus.b_data_out), 32'(sb.data));
                    check("out_done_early", 32'(bus.out_done_out), 32'd0);
                    if (sbq.size() == 0) begin
                        @(negedge clk_in);
                        bus.b_ready_in = 1'b0;
                        check("done_pulse", 32'(bus.out_done_out), 32'd1);
                        check("valid_drop", 32'(bus.b_valid_out), 32'd0);
                        check("busy_idle", 32'(bus.busy_out), 32'd0);
                        @(negedge clk_in);
                        check("done_one_cycle", 32'(bus.out_done_out), 32'd0);
                        fin = 1'b1;
                    end
                end
            end else begin
                bus.b_ready_in = 1'b0;
            end
        end
        if (!fin) begin
            check("out_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.addr_valid_in = 1'b0;
        bus.b_addr_in     = '0;
        bus.e_zero_in     = 1'b0;
        bus.done_in       = 1'b0;
        bus.b_ready_in    = 1'b0;
        cur               = '0;
        #3 rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        zero_checks("reset");
        rst_in = 1'b1;

        // Basic MAC: b[3] = 5*7 + 2 = 37
        model_clear();
        beat(3, 16'd5, 16'd7, 16'd2, 1'b0, 1'b0);
        finish_accum(1'b1);
        out_phase(-1);
        // done_in still high in IDLE: a beat must not start a run
        @(negedge clk_in);
        bus.addr_valid_in = 1'b1;
        bus.b_addr_in     = 13'd4;
        @(negedge clk_in);
        bus.addr_valid_in = 1'b0;
        check("done_high_no_start", 32'(bus.busy_out), 32'd0);
        @(negedge clk_in);
        check("done_high_still_idle", 32'(bus.busy_out), 32'd0);
        bus.done_in = 1'b0;

        // Wrap with e suppressed, twice to idx 0 -> 2; backpressure at idx 2
        model_clear();
        beat(0, 16'hFFFF, 16'hFFFF, 16'd9, 1'b1, 1'b0);
        beat(0, 16'hFFFF, 16'hFFFF, 16'd9, 1'b1, 1'b0);
        beat(2, 16'd1000, 16'd1000, 16'hFFFF, 1'b0, 1'b0);
        finish_accum(1'b0);
        out_phase(2);
        @(negedge clk_in);
        bus.done_in = 1'b0;

        // Out-of-range beats, top in-range index, beat coincident with done
        model_clear();
        beat(5, 16'd10, 16'd20, 16'd3, 1'b0, 1'b0);
        beat(5, 16'd100, 16'd3, 16'd7, 1'b1, 1'b0);
        beat(49, 16'hFFFF, 16'd2, 16'd1, 1'b0, 1'b0);
        beat(50, 16'd9, 16'd9, 16'd9, 1'b0, 1'b0);
        quiet();
        repeat (RL) @(negedge clk_in);
        check("err_before_w", 32'(bus.err_out), 32'd0);
        @(negedge clk_in);
        check("err_at_w", 32'(bus.err_out), 32'd1);
        beat(60, 16'd4, 16'd4, 16'd4, 1'b0, 1'b0);
        beat(7, 16'd2, 16'd2, 16'd2, 1'b0, 1'b1);
        quiet();
        out_phase(-1);
        check("err_sticky", 32'(bus.err_out), 32'd1);
        @(negedge clk_in);
        bus.done_in = 1'b0;

        // Reset mid-ACCUM, then a fresh run: b[1] = 6
        model_clear();
        for (int k = 0; k < 10; k++)
            beat(int'($urandom_range(0, HD - 1)), 16'($urandom), 16'($urandom), 16'($urandom),
                 1'b0, 1'b0);
        @(negedge clk_in);
        bus.addr_valid_in = 1'b0;
        rst_in = 1'b0;
        #1;
        zero_checks("midrst");
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        zero_checks("postrst");
        model_clear();
        beat(1, 16'd2, 16'd3, 16'd0, 1'b0, 1'b0);
        finish_accum(1'b1);
        out_phase(-1);
        @(negedge clk_in);
        bus.done_in = 1'b0;

        // Long run of 2500 in-range beats
        model_clear();
        for (int k = 0; k < 2500; k++) begin
            beat(int'($urandom_range(0, HD - 1)), 16'($urandom), 16'($urandom), 16'($urandom),
                 1'($urandom), 1'b0);
            if (k == 999) check("mac_mid", bus.mac_count_out, (PERF != 0) ? 32'd996 : 32'd0);
        end
        finish_accum(1'b1);
        check("mac_in_out", bus.mac_count_out, (PERF != 0) ? 32'd2500 : 32'd0);
        out_phase(-1);
        @(negedge clk_in);
        bus.done_in = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/enc_mac_accum.md
ENC_MAC_ACCUM -- requirements
Module: enc_mac_accum

Interface
REQ-001 The block SHALL have parameter HALF_DEPTH, default 50, number of b accumulator entries.
REQ-002 The block SHALL have parameter Q_BITS, default 16, coefficient width; modulus q = 2^Q_BITS.
REQ-003 The block SHALL have parameter READ_LAT, default 2, cycles from addr_valid_in to matching BRAM read data.
REQ-004 Ports SHALL be:
- clk_in  in  1  sole clock, rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- addr_valid_in  in  1  address/control beat valid.
- b_addr_in  in  13  target accumulator index.
- e_zero_in  in  1  1 = add no e term.
- done_in  in  1  address generation finished (level; may stay high).
- A_data_in, s_data_in, e_data_in  in  Q_BITS each  BRAM read data, READ_LAT cycles after the beat.
- b_data_out  out  Q_BITS  result word.
- b_idx_out  out  7  result index.
- b_valid_out  out  1  result word valid.
- b_ready_in  in  1  consumer accepts word.
- busy_out  out  1  high in every state except IDLE.
- out_done_out  out  1  one-cycle pulse after the last word is accepted.
- err_out  out  1  sticky out-of-range flag.
- mac_count_out  out  32  accumulated-beat count.

Function
REQ-005 The FSM SHALL have states IDLE, ACCUM, DRAIN and OUT.
REQ-006 IDLE->ACCUM SHALL occur on addr_valid_in=1; in that same cycle, all HALF_DEPTH accumulators SHALL clear to 0.
REQ-007 The control fields (valid, b_addr, e_zero) SHALL be delayed READ_LAT cycles by a shift register and paired with the data arriving at that point.
REQ-008 Stage M (one register) SHALL compute term = (A*s mod 2^Q_BITS) + (e_zero ? 0 : e), mod 2^Q_BITS.
REQ-009 Stage W, the next cycle, SHALL perform acc[b_addr] <= acc[b_addr] + term, mod 2^Q_BITS.
REQ-010 Total latency from a beat to the accumulator update SHALL be READ_LAT+2 cycles.
REQ-011 Back-to-back beats to the same index SHALL accumulate both terms: single write port, read in the W stage, no lost update.
REQ-012 A beat with b_addr >= HALF_DEPTH SHALL leave all accumulators unchanged and SHALL set err_out=1 until reset.
REQ-013 ACCUM->DRAIN SHALL occur on the first cycle done_in=1 in ACCUM, rising-edge detected; a beat valid in that same cycle SHALL still be accumulated.
REQ-014 DRAIN SHALL last exactly READ_LAT+2 cycles and then go to OUT; addr_valid_in SHALL be ignored in DRAIN, OUT and while done_in stays high.
REQ-015 OUT SHALL present idx 0..HALF_DEPTH-1 in order, one word per handshake (b_valid_out & b_ready_in).
REQ-016 While b_valid_out=1 and b_ready_in=0, b_data_out and b_idx_out SHALL remain stable.
REQ-017 On acceptance of idx HALF_DEPTH-1: b_valid_out SHALL drop the next cycle, out_done_out SHALL pulse 1 cycle, and the FSM SHALL return to IDLE.
REQ-018 A new run SHALL start only after done_in has been observed low in IDLE.

Reset
REQ-019 With rst_in=0 asynchronously: state=IDLE; all accumulators, pipeline registers and outputs SHALL be 0.
REQ-020 This SHALL hold for reset in any state, including mid-ACCUM and mid-OUT; no partial result SHALL be emitted afterwards.

Configuration
REQ-021 With macro ENC_MAC_ACCUM_PERF_EN defined:
- mac_count_out SHALL increment once per W-stage in-range beat, wrapping at 2^32.
- It SHALL clear on IDLE->ACCUM and on reset.
REQ-022 Without ENC_MAC_ACCUM_PERF_EN, mac_count_out SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-023 Basic MAC: one beat b_addr=3, A=5, s=7, e=2, e_zero=0, then done_in -> OUT emits b[3]=37, all other entries 0.
REQ-024 Wrap and e suppression: A=0xFFFF, s=0xFFFF, e=9, e_zero=1 to idx 0, twice back-to-back -> b[0]=2 (Q_BITS=16).
REQ-025 Backpressure: b_ready_in=0 for 5 cycles while idx 2 is presented -> idx 2 and its data are stable for all 5 cycles, then the sequence continues 3..49, then one out_done_out pulse.
REQ-026 Out-of-range: beat with b_addr=60 (HALF_DEPTH=50) -> err_out=1 from the W stage on; all 50 outputs equal the same run without that beat.
REQ-027 Reset mid-ACCUM: after 10 beats, drive rst_in=0 for 1 cycle -> all outputs 0 and IDLE; a fresh run with one beat (idx 1, A=2, s=3, e=0) gives b[1]=6.
REQ-028 With ENC_MAC_ACCUM_PERF_EN, a full run of 2500 in-range beats -> mac_count_out=2500 in OUT; without the macro, mac_count_out=0 throughout.
